// File: rtl/gcd_ctrl.sv
// rtl/gcd_ctrl.sv - Moore control FSM for a subtractive GCD datapath
// Optional iteration counter enabled by defining GCD_CTRL_ITER_CNT_EN.
module gcd_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             operands_val,
  output logic             operands_rdy,
  output logic             result_val,
  input  logic             result_rdy,
  input  logic             B_zero,
  input  logic             A_lt_B,
  output logic             A_en,
  output logic             B_en,
  output logic [1:0]       A_mux_sel,
  output logic             B_mux_sel
`ifdef GCD_CTRL_ITER_CNT_EN
  ,
  output logic [CNT_W-1:0] iter_count
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    SWAP  = 3'd3,
    SUB   = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rdy_nxt;
  logic       val_nxt;
  logic       a_en_nxt;
  logic       b_en_nxt;
  logic [1:0] a_sel_nxt;
  logic       b_sel_nxt;

  // A zero-width counter would make the optional port meaningless.
  if (CNT_W == 0) begin : g_bad_cnt_w
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (operands_val) state_nxt = LOAD;
      LOAD:      state_nxt = CHECK;
      CHECK: begin
        if (A_lt_B)      state_nxt = SWAP;
        else if (B_zero) state_nxt = DONE;
        else             state_nxt = SUB;
      end
      SWAP, SUB: state_nxt = CHECK;
      DONE:      if (result_rdy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are
  // clean flop outputs that still line up exactly with the current state.
  always_comb begin
    rdy_nxt   = 1'b0;
    val_nxt   = 1'b0;
    a_en_nxt  = 1'b0;
    b_en_nxt  = 1'b0;
    a_sel_nxt = 2'b00;
    b_sel_nxt = 1'b0;
    case (state_nxt)
      IDLE: rdy_nxt = 1'b1;
      LOAD: begin
        a_en_nxt  = 1'b1;
        b_en_nxt  = 1'b1;
        b_sel_nxt = 1'b1;
      end
      SWAP: begin
        a_en_nxt  = 1'b1;
        b_en_nxt  = 1'b1;
        a_sel_nxt = 2'b10;
      end
      SUB: begin
        a_en_nxt  = 1'b1;
        a_sel_nxt = 2'b01;
      end
      DONE:    val_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      operands_rdy <= 1'b1;
      result_val   <= 1'b0;
      A_en         <= 1'b0;
      B_en         <= 1'b0;
      A_mux_sel    <= 2'b00;
      B_mux_sel    <= 1'b0;
    end else begin
      state        <= state_nxt;
      operands_rdy <= rdy_nxt;
      result_val   <= val_nxt;
      A_en         <= a_en_nxt;
      B_en         <= b_en_nxt;
      A_mux_sel    <= a_sel_nxt;
      B_mux_sel    <= b_sel_nxt;
    end
  end

`ifdef GCD_CTRL_ITER_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      iter_count <= '0;
    end else if (state == IDLE && operands_val) begin
      iter_count <= '0;
    end else if ((state == SWAP || state == SUB) && iter_count != '1) begin
      iter_count <= iter_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/gcd_ctrl.md
GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of iteration counter (used only with GCD_CTRL_ITER_CNT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 operands_val  input  1  requester presents operand pair to datapath operand inputs.
REQ-005 operands_rdy  output  1  block can accept a new operand pair.
REQ-006 result_val  output  1  datapath result_data holds GCD.
REQ-007 result_rdy  input  1  consumer accepts result.
REQ-008 B_zero  input  1  datapath status: register B equals 0.
REQ-009 A_lt_B  input  1  datapath status: register A less than register B.
REQ-010 A_en  output  1  datapath A register capture strobe (datapath captures on its rising edge).
REQ-011 B_en  output  1  datapath B register capture strobe (datapath captures on its rising edge).
REQ-012 A_mux_sel  output  2  A source: 00 operand_A, 01 A-B, 10 register B.
REQ-013 B_mux_sel  output  1  B source: 0 register A, 1 operand_B.
REQ-014 iter_count  output  CNT_W  completed SWAP+SUB steps; present only with GCD_CTRL_ITER_CNT_EN.

Function
REQ-015 Moore FSM, states IDLE, LOAD, CHECK, SWAP, SUB, DONE; all outputs registered/state-decoded, glitch-free.
REQ-016 IDLE: operands_rdy=1, strobes 0; operands_val=1 at edge -> LOAD.
REQ-017 LOAD (1 cycle): A_en=1, B_en=1, A_mux_sel=00, B_mux_sel=1; -> CHECK.
REQ-018 CHECK (1 cycle): strobes 0; status sampled at end of cycle; A_lt_B=1 -> SWAP; else B_zero=1 -> DONE; else -> SUB (A_lt_B has priority).
REQ-019 SWAP (1 cycle): A_en=1, B_en=1, A_mux_sel=10, B_mux_sel=0; -> CHECK.
REQ-020 SUB (1 cycle): A_en=1, B_en=0, A_mux_sel=01, B_mux_sel=0; -> CHECK.
REQ-021 Every strobe is a single-cycle pulse preceded and followed by a low cycle, guaranteeing one datapath rising edge per step.
REQ-022 A_mux_sel/B_mux_sel outside active states: 00/0; value 11 never driven.
REQ-023 DONE: result_val=1, operands_rdy=0, strobes 0; result_rdy=1 at edge -> IDLE; result_val held until then.
REQ-024 Latency: result_val first high 2*N+3 cycles after acceptance edge, N = SWAP+SUB steps.
REQ-025 operands_val outside IDLE ignored; result_rdy outside DONE ignored.
REQ-026 A=0,B=0 -> DONE after one CHECK (result 0); A=0,B=x -> one SWAP then DONE.
REQ-027 No timeout; termination guaranteed by Euclid subtraction for any unsigned inputs.

Reset
REQ-028 rst=1 at edge -> IDLE from any state, including mid-computation; pending result discarded.
REQ-029 Values after reset: operands_rdy=1, result_val=0, A_en=0, B_en=0, A_mux_sel=00, B_mux_sel=0, iter_count=0.
REQ-030 rst has priority over operands_val and result_rdy in the same cycle.

Configuration
REQ-031 Macro GCD_CTRL_ITER_CNT_EN defined: iter_count port present; cleared on acceptance, +1 on each SWAP/SUB cycle, saturates at all-ones, held through DONE and IDLE until next acceptance.
REQ-032 Macro undefined: iter_count port and counter logic absent; all other behaviour identical.

Verification
REQ-033 A=12,B=8 accepted -> steps SUB,SWAP,SUB,SUB,SWAP; result_val at cycle 13 after acceptance; result_data=4; iter_count=5.
REQ-034 A=0,B=0 -> LOAD, CHECK, DONE; result_val at cycle 3; result 0; iter_count=0.
REQ-035 A=0,B=9 -> one SWAP; result_val at cycle 5; result 9; A_en/B_en each pulse exactly twice.
REQ-036 result_rdy held low 10 cycles in DONE -> result_val stays 1, operands_val ignored; result_rdy=1 -> IDLE next cycle, operands_rdy=1.
REQ-037 rst asserted during SUB for A=255,B=1 -> next cycle IDLE, strobes 0, result_val 0; new pair 6,4 then yields 2.
REQ-038 CNT_W=4, A=255,B=1 with macro -> iter_count saturates at 15, result 1.
